press_pulse_gen: RTL and testbench

//  Upstream stage of the 8-bit enable counter: turns a raw, bouncy, asynchronous

---
 rtl/press_pulse_gen.sv | 186 ++++++++++++++++++
 tb/tb_press_pulse_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/press_pulse_gen.sv
// press_pulse_gen
//   Turns a raw, bouncy, asynchronous push-button level into clean single-cycle
//   enable pulses for a downstream counter. The button is brought into the clock
//   domain through a two-flop synchroniser. A debounce FSM then accepts a press
//   or a release only after the synchronised level has been stable long enough.
//   While the button is held, the block can optionally produce auto-repeat pulses.
//
// Parameters
//   DEBOUNCE_CYCLES  stable synchronised cycles needed to accept a press/release
//   REPEAT_DELAY     held cycles from the first pulse to the first repeat pulse
//   REPEAT_PERIOD    cycles between later repeat pulses
//
// Ports
//   clk        in   single clock for all state
//   rst        in   asynchronous, active-high reset
//   btn_in     in   raw button level (asynchronous to clk, may bounce)
//   repeat_en  in   1 = auto-repeat while held, 0 = one pulse per press
//   en         out  registered one-cycle pulse per accepted press or repeat
//   pressed    out  registered debounced level (held or debouncing a release)

module press_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic repeat_en,
    output logic en,
    output logic pressed
);

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_e;

    logic             s1_q;
    logic             btn_s_q;
    state_e           state_q, state_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             first_q, first_d;
    logic             fire_q, fire_d;
    logic             en_q, en_d;
    logic             pressed_q, pressed_d;
    logic [REP_W-1:0] rep_limit;

    // Two-flop synchroniser for the asynchronous button level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            btn_s_q <= 1'b0;
        end else begin
            s1_q    <= btn_in;
            btn_s_q <= s1_q;
        end
    end

    // State register, debounce and repeat counters.
    // fire_q marks the edge on which a pulse was decided.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            db_cnt_q  <= '0;
            rep_cnt_q <= '0;
            first_q   <= 1'b0;
            fire_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            first_q   <= first_d;
            fire_q    <= fire_d;
        end
    end

    // The first repeat waits the long delay.
    // Later repeats use the shorter period.
    assign rep_limit = first_q ? DELAY_LAST : PERIOD_LAST;

    // Next-state logic.
    // Every state entry clears both counters, so neither counter can wrap.
    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        rep_cnt_d = rep_cnt_q;
        first_d   = first_q;
        fire_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_s_q) begin
                    state_d   = DB_PRESS;
                    db_cnt_d  = '0;
                    rep_cnt_d = '0;
                end
            end
            DB_PRESS: begin
                if (!btn_s_q) begin
                    state_d   = IDLE;
                    db_cnt_d  = '0;
                    rep_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = HELD;
                    fire_d    = 1'b1;
                    db_cnt_d  = '0;
                    rep_cnt_d = '0;
                    first_d   = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            HELD: begin
                if (!btn_s_q) begin
                    state_d   = DB_RELEASE;
                    db_cnt_d  = '0;
                    rep_cnt_d = '0;
                end else if (repeat_en) begin
                    if (rep_cnt_q == rep_limit) begin
                        fire_d    = 1'b1;
                        rep_cnt_d = '0;
                        first_d   = 1'b0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end else begin
                    // Re-enabling repeat later restarts the full initial delay.
                    rep_cnt_d = '0;
                    first_d   = 1'b1;
                end
            end
            DB_RELEASE: begin
                if (btn_s_q) begin
                    state_d   = HELD;
                    db_cnt_d  = '0;
                    rep_cnt_d = '0;
                    first_d   = 1'b1;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    db_cnt_d  = '0;
                    rep_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode.
    // en follows the fire flag.
    // pressed covers both held states, including a release that is still debouncing.
    always_comb begin
        en_d      = fire_q;
        pressed_d = (state_q == HELD) || (state_q == DB_RELEASE);
    end

    // Output register.
    // The outputs are flops so the counter's enable input sees a glitch-free signal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q      <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            en_q      <= en_d;
            pressed_q <= pressed_d;
        end
    end

    assign en      = en_q;
    assign pressed = pressed_q;

endmodule

// File: tb/tb_press_pulse_gen.sv
// tb_press_pulse_gen
//   Bench for press_pulse_gen.
//   Two instances share one set of stimulus:
//     dutA  uses the default parameters.
//     dutB  uses short parameters (one-cycle debounce, repeat every cycle).
//   Expected en/pressed values come from a run-length model of the button.
//   The model is written in terms of consecutive equal samples of the
//   synchronised level and counts of qualifying held cycles.

module tb_press_pulse_gen;

    localparam int A_DB = 4;
    localparam int A_DLY = 16;
    localparam int A_PER = 8;
    localparam int B_DB = 1;
    localparam int B_DLY = 2;
    localparam int B_PER = 1;

    logic clk;
    logic rst;
    logic btnIn;
    logic repeatEn;
    logic enA, pressedA, enB, pressedB;

    int checkCount = 0;
    int passCount = 0;
    int failCount = 0;
    int cycle = 0;
    int enCountA = 0;

    typedef struct {
        int run1;
        int run0;
        int hc;
        int gap;
        bit lvl;
        bit prevS;
        bit b1;
        bit b2;
        bit evPrev;
        bit lPrev;
    } model_t;

    model_t mA, mB;

    press_pulse_gen #(.DEBOUNCE_CYCLES(A_DB), .REPEAT_DELAY(A_DLY), .REPEAT_PERIOD(A_PER)) dutA (
        .clk(clk), .rst(rst), .btn_in(btnIn), .repeat_en(repeatEn), .en(enA), .pressed(pressedA)
    );

    press_pulse_gen #(.DEBOUNCE_CYCLES(B_DB), .REPEAT_DELAY(B_DLY), .REPEAT_PERIOD(B_PER)) dutB (
        .clk(clk), .rst(rst), .btn_in(btnIn), .repeat_en(repeatEn), .en(enB), .pressed(pressedB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic model_t modelReset(input int dly);
        model_t m;
        m.run1 = 0;
        m.run0 = 0;
        m.hc = 0;
        m.gap = dly;
        m.lvl = 0;
        m.prevS = 0;
        m.b1 = 0;
        m.b2 = 0;
        m.evPrev = 0;
        m.lPrev = 0;
        return m;
    endfunction

    // One clock edge of the reference model.
    // The synchronised sample seen at this edge is the button value from two edges earlier.
    // A press is accepted after db+1 consecutive high samples.
    // A release is accepted after db+1 consecutive low samples.
    // A repeat pulse fires after `gap` consecutive qualifying held samples.
    // Outputs appear one edge after the model decides them.
    task automatic modelStep(inout model_t m, input bit bNow, input bit r, input int db,
                             input int dly, input int per, output bit expEn, output bit expP);
        bit s;
        bit ev;
        expEn = m.evPrev;
        expP = m.lPrev;
        s = m.b2;
        ev = 0;
        if (!m.lvl) begin
            if (s) m.run1++;
            else m.run1 = 0;
            if (m.run1 == db + 1) begin
                m.lvl = 1;
                ev = 1;
                m.run1 = 0;
                m.hc = 0;
                m.gap = dly;
            end
        end else begin
            if (s && m.prevS && r) begin
                m.hc++;
                if (m.hc == m.gap) begin
                    ev = 1;
                    m.hc = 0;
                    m.gap = per;
                end
            end else begin
                m.hc = 0;
                m.gap = dly;
            end
            if (!s) m.run0++;
            else m.run0 = 0;
            if (m.run0 == db + 1) begin
                m.lvl = 0;
                m.run0 = 0;
            end
        end
        m.prevS = s;
        m.evPrev = ev;
        m.lPrev = m.lvl;
        m.b2 = m.b1;
        m.b1 = bNow;
    endtask

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s cycle=%0d observed=%0b expected=%0b", tag, cycle, obs, exp);
        end
    endtask

    task automatic checkValue(input string tag, input int obs, input int exp);
        checkCount++;
        assert (obs == exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs.
    // Step both models for that edge and compare both DUTs just after the edge.
    task automatic applyStimulus(input bit b, input bit r);
        bit eA, pA, eB, pB;
        btnIn = b;
        repeatEn = r;
        @(posedge clk);
        #1;
        cycle++;
        modelStep(mA, b, r, A_DB, A_DLY, A_PER, eA, pA);
        modelStep(mB, b, r, B_DB, B_DLY, B_PER, eB, pB);
        checkOutput("A.en", enA, eA);
        checkOutput("A.pressed", pressedA, pA);
        checkOutput("B.en", enB, eB);
        checkOutput("B.pressed", pressedB, pB);
        if (enA) enCountA++;
    endtask

    task automatic holdLevel(input bit b, input bit r, input int n);
        for (int i = 0; i < n; i++) applyStimulus(b, r);
    endtask

    initial begin
        rst = 1'b1;
        btnIn = 1'b0;
        repeatEn = 1'b0;
        mA = modelReset(A_DLY);
        mB = modelReset(B_DLY);

        // Reset state.
        #12;
        checkOutput("reset.A.en", enA, 1'b0);
        checkOutput("reset.A.pressed", pressedA, 1'b0);
        checkOutput("reset.B.en", enB, 1'b0);
        checkOutput("reset.B.pressed", pressedB, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Short bounce: three high cycles must not be accepted.
        enCountA = 0;
        holdLevel(1'b1, 1'b0, 3);
        holdLevel(1'b0, 1'b0, 10);
        checkValue("bounce.count", enCountA, 0);

        // Single press, no repeat: exactly one pulse.
        enCountA = 0;
        holdLevel(1'b1, 1'b0, 30);
        holdLevel(1'b0, 1'b0, 12);
        checkValue("single.count", enCountA, 1);

        // Auto-repeat: pulses at T, T+16, T+24 and T+32.
        enCountA = 0;
        holdLevel(1'b1, 1'b1, 43);
        holdLevel(1'b0, 1'b1, 12);
        checkValue("repeat.count", enCountA, 4);

        // Two-cycle dropout while held: no extra pulse, and the repeat delay restarts.
        holdLevel(1'b1, 1'b1, 20);
        holdLevel(1'b0, 1'b1, 2);
        holdLevel(1'b1, 1'b1, 25);
        holdLevel(1'b0, 1'b1, 12);

        // Asynchronous reset while en is high.
        holdLevel(1'b1, 1'b0, 8);
        checkOutput("preReset.A.en", enA, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("asyncReset.A.en", enA, 1'b0);
        checkOutput("asyncReset.A.pressed", pressedA, 1'b0);
        checkOutput("asyncReset.B.pressed", pressedB, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mA = modelReset(A_DLY);
        mB = modelReset(B_DLY);

        // The button is still high after reset, so a full debounce must run again.
        enCountA = 0;
        holdLevel(1'b1, 1'b0, 6);
        checkValue("postReset.noEarlyPulse", enCountA, 0);
        holdLevel(1'b1, 1'b0, 2);
        checkValue("postReset.pulse", enCountA, 1);
        holdLevel(1'b0, 1'b0, 12);

        // Five clean presses drive the downstream counter from 0 to 5.
        enCountA = 0;
        for (int p = 0; p < 5; p++) begin
            holdLevel(1'b1, 1'b0, 8);
            holdLevel(1'b0, 1'b0, 10);
        end
        checkValue("counter.five", enCountA, 5);

        // Randomised segments of bouncing, holding and repeat_en changes.
        begin
            bit lvl;
            bit r;
            lvl = 1'b0;
            for (int seg = 0; seg < 80; seg++) begin
                lvl = ~lvl;
                r = ($urandom_range(0, 3) != 0);
                holdLevel(lvl, r, $urandom_range(1, 12));
            end
            holdLevel(1'b0, 1'b0, 12);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
